// File: rtl/ddc_frame_packer.sv
// Frames each DDC burst as a header plus N_CH I/Q words in a commit/rollback FIFO and streams it out on 128-bit AXI-Stream.
// Optional DDC_FRAME_PACKER_TIMESTAMP_EN places a free-running cycle count in header [31:0].
module ddc_frame_packer #(
    parameter int          N_CH      = 4,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] HDR_MAGIC = 32'hDDC0_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [95:0]  s_axis_ddc_tdata,
    input  logic         s_axis_ddc_tvalid,
    output logic         s_axis_ddc_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [31:0]  frame_cnt,
    output logic [31:0]  drop_cnt,
    output logic [31:0]  err_cnt,
    output logic [1:0]   o_dbg_state
);
    localparam int            AW     = $clog2(DEPTH);
    localparam int            PW     = AW + 1;
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [15:0]   NCH16  = 16'(N_CH);
    localparam logic          ONE_CH = (N_CH == 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DISCARD} state_t;

    state_t        r_state, w_state_nxt;
    logic [127:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_cm_vis;
    logic [PW-1:0] w_wr_ptr_nxt, w_free, w_ld_addr;
    logic [127:0]  r_dly, w_wdata, w_header, w_beat_word;
    logic [15:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [16:0]   w_beat_inc, r_rd_idx;
    logic [31:0]   r_seq_cnt, r_frame_cnt, r_drop_cnt, r_err_cnt, w_ts;
    logic          w_we, w_latch, w_commit, w_seq_inc, w_drop_inc, w_err_inc;
    logic          w_space_ok, w_fire, w_need, w_avail;
    logic [127:0]  r_tdata;
    logic          r_tvalid, r_tlast;

`ifdef DDC_FRAME_PACKER_TIMESTAMP_EN
    logic [31:0] r_ts;
    always_ff @(posedge clk) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + 32'd1;
    end
    assign w_ts = r_ts;
`else
    assign w_ts = '0;
`endif

    // Occupancy counts the word held in the output stage until it is handshaken.
    assign w_free      = PW'(DEPTH) - (r_cm_ptr - r_rd_ptr);
    assign w_space_ok  = (32'(w_free) >= 32'(N_CH + 1));
    assign w_beat_inc  = {1'b0, r_beat_cnt} + 17'd1;
    assign w_header    = {HDR_MAGIC, r_seq_cnt, NCH16, r_drop_cnt[15:0], w_ts};
    assign w_beat_word = {{16{s_axis_ddc_tdata[95]}}, s_axis_ddc_tdata[95:48],
                          {16{s_axis_ddc_tdata[47]}}, s_axis_ddc_tdata[47:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_we           = 1'b0;
        w_wdata        = r_dly;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_latch        = 1'b0;
        w_commit       = 1'b0;
        w_seq_inc      = 1'b0;
        w_drop_inc     = 1'b0;
        w_err_inc      = 1'b0;
        case (r_state)
            IDLE: if (s_axis_ddc_tvalid) begin
                w_seq_inc = 1'b1;
                if (w_space_ok) begin
                    w_we           = 1'b1;
                    w_wdata        = w_header;
                    w_wr_ptr_nxt   = r_wr_ptr + P_ONE;
                    w_latch        = 1'b1;
                    w_beat_cnt_nxt = 16'd1;
                    w_state_nxt    = ONE_CH ? FLUSH : COLLECT;
                end else begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = DISCARD;
                end
            end
            COLLECT: begin
                w_we = 1'b1;
                if (s_axis_ddc_tvalid) begin
                    w_wr_ptr_nxt   = r_wr_ptr + P_ONE;
                    w_latch        = 1'b1;
                    w_beat_cnt_nxt = w_beat_inc[15:0];
                    if (w_beat_inc == 17'(N_CH)) w_state_nxt = FLUSH;
                end else begin
                    w_wr_ptr_nxt = r_cm_ptr;
                    w_err_inc    = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            FLUSH: begin
                w_we = 1'b1;
                if (s_axis_ddc_tvalid) begin
                    w_wr_ptr_nxt = r_cm_ptr;
                    w_err_inc    = 1'b1;
                    w_state_nxt  = DISCARD;
                end else begin
                    w_wr_ptr_nxt = r_wr_ptr + P_ONE;
                    w_commit     = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            DISCARD: if (!s_axis_ddc_tvalid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we && !rst) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_cm_ptr    <= '0;
            r_dly       <= '0;
            r_beat_cnt  <= '0;
            r_seq_cnt   <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if (w_latch)    r_dly       <= w_beat_word;
            if (w_commit)   r_cm_ptr    <= w_wr_ptr_nxt;
            if (w_commit)   r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_seq_inc)  r_seq_cnt   <= r_seq_cnt + 32'd1;
            if (w_drop_inc) r_drop_cnt  <= r_drop_cnt + 32'd1;
            if (w_err_inc)  r_err_cnt   <= r_err_cnt + 32'd1;
        end
    end

    // r_rd_ptr addresses the word in the output stage; the refill fetches the one after it.
    assign w_fire    = r_tvalid & m_axis_tready;
    assign w_need    = ~r_tvalid | w_fire;
    assign w_ld_addr = r_rd_ptr + PW'(r_tvalid);
    assign w_avail   = (w_ld_addr != r_cm_vis);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_cm_vis <= '0;
            r_rd_idx <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            r_cm_vis <= r_cm_ptr;
            if (w_fire) r_rd_ptr <= r_rd_ptr + P_ONE;
            if (w_need) begin
                r_tvalid <= w_avail;
                r_tlast  <= w_avail && (r_rd_idx == 17'(N_CH));
                if (w_avail) begin
                    r_tdata  <= r_mem[w_ld_addr[AW-1:0]];
                    r_rd_idx <= (r_rd_idx == 17'(N_CH)) ? 17'd0 : r_rd_idx + 17'd1;
                end
            end
        end
    end

    assign s_axis_ddc_tready = ~rst;
    assign m_axis_tdata      = r_tdata;
    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tlast      = r_tlast;
    assign frame_cnt         = r_frame_cnt;
    assign drop_cnt          = r_drop_cnt;
    assign err_cnt           = r_err_cnt;
    assign o_dbg_state       = r_state;
endmodule
